// File: rtl/inv_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : inv_key_scheduler
//  Description : Sequential AES-128 key schedule for the decryption datapath.
//                The cipher key is expanded forward one round per clock until
//                K10 is reached. The key set is then walked backwards, K10
//                down to K0, with one inverse round per accepted key, so only
//                a single 128-bit round key is ever stored.
//  Ports       : clk        - rising-edge clock
//                rstN       - asynchronous active-low reset
//                start      - begin a schedule (sampled in IDLE only)
//                cipherKey  - 128-bit AES key, word 0 = [127:96]
//                abort      - synchronous flush to IDLE, highest priority
//                keyReady   - consumer accepts roundKey when keyValid is high
//                keyValid   - roundKey / roundIdx valid
//                roundKey   - current round key, word 0 = [127:96]
//                roundIdx   - index of roundKey, 10 down to 0
//                busy       - schedule in progress (FWD or REV)
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_key_scheduler #(
    // Only 10 (AES-128) is legal; the round-constant table covers 1..10.
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         start,
    input  logic [127:0] cipherKey,
    input  logic         abort,
    input  logic         keyReady,
    output logic         keyValid,
    output logic [127:0] roundKey,
    output logic [3:0]   roundIdx,
    output logic         busy
);

    localparam logic [3:0] C_LAST_RND = 4'(NUM_ROUNDS);

    localparam logic [7:0] C_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_REV  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // SubWord(RotWord(w)): rotate left by one byte, then S-box each byte.
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {C_SBOX[w[23:16]], C_SBOX[w[15:8]], C_SBOX[w[7:0]], C_SBOX[w[31:24]]};
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     rnd_q, rnd_d;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_sub_in;
    logic [3:0]     w_rcon_idx;
    logic [31:0]    w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_fwd_key, w_inv_key;

    assign {w_w0, w_w1, w_w2, w_w3} = key_q;

    // One S-box word is shared by both directions: the forward step feeds w3,
    // the inverse step feeds the recovered previous w3 (= w3 ^ w2). The Rcon
    // index is the round being produced (FWD) or undone (REV).
    assign w_sub_in   = (state_q == S_REV) ? (w_w3 ^ w_w2) : w_w3;
    assign w_rcon_idx = (state_q == S_REV) ? rnd_q : (rnd_q + 4'd1);
    assign w_t        = sub_rot(w_sub_in) ^ {rcon(w_rcon_idx), 24'h0};

    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_fwd_key = {w_n0, w_n1, w_n2, w_n3};
    assign w_inv_key = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = cipherKey;
                    rnd_d   = 4'd0;
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                key_d = w_fwd_key;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == C_LAST_RND - 4'd1) begin
                    state_d = S_REV;
                end
            end
            S_REV: begin
                if (keyReady) begin
                    if (rnd_q == 4'd0) begin
                        // Key register keeps K0 so outputs hold in IDLE.
                        state_d = S_IDLE;
                    end else begin
                        key_d = w_inv_key;
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle start.
        if (abort) begin
            state_d = S_IDLE;
            key_d   = key_q;
            rnd_d   = rnd_q;
        end
    end

    assign keyValid = (state_q == S_REV);
    assign busy     = (state_q != S_IDLE);
    assign roundKey = key_q;
    assign roundIdx = rnd_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_key_scheduler
//  Description : Self-checking bench for inv_key_scheduler. Expected round
//                keys come from a textbook forward AES-128 key expansion with
//                an S-box derived from GF(2^8) inversion plus the affine map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_key_scheduler;

    localparam logic [127:0] C_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rstN;
    logic         start;
    logic [127:0] cipherKey;
    logic         abort;
    logic         keyReady;
    logic         keyValid;
    logic [127:0] roundKey;
    logic [3:0]   roundIdx;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox    [0:255];
    logic [127:0] exp_key [0:10];

    inv_key_scheduler #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .cipherKey (cipherKey),
        .abort     (abort),
        .keyReady  (keyReady),
        .keyValid  (keyValid),
        .roundKey  (roundKey),
        .roundIdx  (roundIdx),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = key;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) exp_key[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_kv"}, keyValid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk128({tag, "_key"}, roundKey, 128'h0);
        chk4({tag, "_idx"}, roundIdx, 4'd0);
    endtask

    // One schedule. rand_ready: random back-pressure. pulse: extra start
    // pulses while busy. abort_fwd: FWD cycle (1..10) carrying abort, 0 = none.
    // abort_idx / rst_idx: REV index at which to abort / reset, -1 = none.
    task automatic run_sched(input logic [127:0] key, input bit rand_ready, input bit pulse,
                             input int abort_fwd, input int abort_idx, input int rst_idx);
        int  exp_idx;
        bit  hs;
        bit  done;
        build_model(key);
        chk1("pre_idle_busy", busy, 1'b0);
        cipherKey = key;
        start     = 1'b1;
        step();
        start     = 1'b0;
        cipherKey = {$urandom, $urandom, $urandom, $urandom};
        chk1("fwd_busy", busy, 1'b1);
        chk1("fwd_kv", keyValid, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            start    = pulse && (i == 4 || i == 7);
            keyReady = 1'($urandom_range(0, 1));
            if (abort_fwd == i) begin
                abort = 1'b1;
                start = 1'b1;
            end
            step();
            if (abort) begin
                abort = 1'b0;
                chk1("abort_fwd_kv", keyValid, 1'b0);
                chk1("abort_fwd_busy", busy, 1'b0);
                start = 1'b0;
                step();
                chk1("abort_fwd_start_dropped", busy, 1'b0);
                return;
            end
            chk1("fwd_latency_kv", keyValid, (i == 10));
        end
        start   = 1'b0;
        exp_idx = 10;
        done    = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            chk1("rev_kv", keyValid, 1'b1);
            chk4("rev_idx", roundIdx, 4'(exp_idx));
            chk128("rev_key", roundKey, exp_key[exp_idx]);
            if (key == C_FIPS_KEY && exp_idx == 10) chk128("fips_k10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            if (key == C_FIPS_KEY && exp_idx == 9)  chk128("fips_k9", roundKey, 128'hac7766f319fadc2128d12941575c006e);
            if (key == C_FIPS_KEY && exp_idx == 1)  chk128("fips_k1", roundKey, 128'ha0fafe1788542cb123a339392a6c7605);
            if (key == 128'h0 && exp_idx == 10)     chk128("zero_k10", roundKey, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
            if (abort_idx == exp_idx) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk1("abort_rev_kv", keyValid, 1'b0);
                chk1("abort_rev_busy", busy, 1'b0);
                return;
            end
            if (rst_idx == exp_idx) begin
                #2 rstN = 1'b0;
                #1 chk_all_zero("async_rst");
                @(negedge clk);
                rstN = 1'b1;
                step();
                for (int k = 0; k < 3; k++) begin
                    chk_all_zero("post_rst_idle");
                    step();
                end
                return;
            end
            keyReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = pulse && (($urandom_range(0, 3) == 0) || exp_idx == 0);
            hs       = keyReady;
            step();
            start = 1'b0;
            if (hs) begin
                if (exp_idx == 0) done = 1'b1;
                else exp_idx--;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $error("FAIL rev_timeout observed=idx%0d expected=complete", exp_idx);
        end
        chk1("end_kv", keyValid, 1'b0);
        chk1("end_busy", busy, 1'b0);
        chk4("end_idx_hold", roundIdx, 4'd0);
        chk128("end_key_hold", roundKey, exp_key[0]);
        keyReady = 1'b0;
        step();
        chk1("end_busy_next", busy, 1'b0);
    endtask

    initial begin
        rstN      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        keyReady  = 1'b0;
        cipherKey = '0;
        build_sbox();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rstN = 1'b1;
        step();

        run_sched(C_FIPS_KEY, 1'b0, 1'b0, 0, -1, -1);
        run_sched(C_FIPS_KEY, 1'b1, 1'b0, 0, -1, -1);
        run_sched(128'h0, 1'b1, 1'b0, 0, -1, -1);
        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 0, -1, -1);

        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 5, -1, -1);
        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 0, -1, -1);
        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 0, 6, -1);
        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 0, -1, -1);

        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 0, -1, 5);
        run_sched(C_FIPS_KEY, 1'b1, 1'b1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
